rfphoenix_ifetch_queue: RTL and testbench

- Per-thread instruction queue between the I$ fetch stage and decode.
- Accepts one InstructionFetchbuf per cycle from fetch, tagged with its thread.
- Buffers entries in per-thread FIFOs.
- Issues one entry per cycle to decode through a registered output, choosing the thread round-robin.
- Supports per-thread flush (branch redirect, exception) and per-thread sleep gating.

---
 rtl/rfphoenix_ifetch_queue_pkg.sv | 35 +++
 rtl/rfphoenix_ifetch_queue_rr_pick.sv | 27 ++
 rtl/rfphoenix_ifetch_queue.sv | 125 ++++++++++++
 tb/tb_rfphoenix_ifetch_queue.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rfphoenix_ifetch_queue_pkg.sv
// Shared fetch-side types: thread id, fault cause, fetch buffer entry and the
// instruction-queue occupancy/pointer types.
package rfphoenix_ifetch_queue_pkg;

    localparam int NTHREADS  = 4;
    localparam int IFQ_DEPTH = 4;
    localparam int TID_W     = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;

    typedef logic [TID_W-1:0] Tid;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_IMISALIGN = 3'd1,
        FLT_IACCESS  = 3'd2,
        FLT_IPF      = 3'd3,
        FLT_ITLB     = 3'd4
    } CauseCode;

    typedef struct packed {
        logic        v;
        Tid          thread;
        logic [31:0] ip;
        logic [31:0] insn;
        CauseCode    cause;
    } InstructionFetchbuf;

    typedef logic [$clog2(IFQ_DEPTH):0]   ifq_cnt_t;
    typedef logic [$clog2(IFQ_DEPTH)-1:0] ifq_ptr_t;

    // Cyclic successor, valid for non-power-of-two thread counts too.
    function automatic Tid tid_next(input Tid t);
        return (int'(t) == NTHREADS - 1) ? '0 : Tid'(t + 1'b1);
    endfunction

endpackage

// File: rtl/rfphoenix_ifetch_queue_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr, cyclic.
module rfphoenix_rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr,
    output logic [W-1:0] grant,
    output logic         found
);

    int idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(rr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/rfphoenix_ifetch_queue.sv
// Per-thread instruction queue between I$ fetch and decode: per-thread FIFOs,
// round-robin issue through a single registered output stage.
module rfphoenix_ifetch_queue
    import rfphoenix_ifetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  InstructionFetchbuf                    ifb_i,
    input  logic                                  ifb_v_i,
    output logic [NTHREADS-1:0]                   full_o,
    input  logic [NTHREADS-1:0]                   flush_i,
    input  logic [NTHREADS-1:0]                   sleep_i,
    output InstructionFetchbuf                    ifb_o,
    output logic                                  ifb_v_o,
    input  logic                                  dec_rdy_i,
    output logic [NTHREADS*($clog2(DEPTH)+1)-1:0] cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    cnt_t               cnt [NTHREADS];
    InstructionFetchbuf head_ent [NTHREADS];
    logic [NTHREADS-1:0] req;
    logic [NTHREADS-1:0] full;
    Tid                 pt;
    Tid                 rr;
    Tid                 grant;
    logic               found;
    logic               push;
    logic               free;
    logic               pop;

    always_comb begin
        full = '0;
        req  = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            full[t] = (cnt[t] == CW'(DEPTH));
            req[t]  = (cnt[t] != '0) && !sleep_i[t] && !flush_i[t];
        end
    end

    assign pt     = ifb_i.thread;
    assign push   = ifb_v_i && ifb_i.v && !full[pt] && !flush_i[pt];
    assign free   = !ifb_v_o || dec_rdy_i;
    assign pop    = free && found;
    assign full_o = full;

    rfphoenix_rr_pick #(.N(NTHREADS), .W(TID_W)) u_pick (
        .req   (req),
        .rr    (rr),
        .grant (grant),
        .found (found)
    );

    for (genvar t = 0; t < NTHREADS; t++) begin : g_thr
        cnt_t               cnt_q;
        ptr_t               head_q;
        ptr_t               tail_q;
        InstructionFetchbuf q [DEPTH];
        logic               inc;
        logic               dec;

        assign inc = push && (pt == Tid'(t));
        assign dec = pop && (grant == Tid'(t));

        always_ff @(posedge clk) begin
            if (!rst_n || flush_i[t]) begin
                cnt_q  <= '0;
                head_q <= '0;
                tail_q <= '0;
            end else begin
                // Pointers wrap naturally since DEPTH is a power of two.
                if (inc) tail_q <= tail_q + 1'b1;
                if (dec) head_q <= head_q + 1'b1;
                cnt_q <= cnt_q + CW'(inc) - CW'(dec);
            end
        end

        always_ff @(posedge clk) begin
            if (inc) q[tail_q] <= ifb_i;
        end

        assign cnt[t]      = cnt_q;
        assign head_ent[t] = q[head_q];
        assign cnt_o[t*CW +: CW] = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifb_o   <= '0;
            ifb_v_o <= 1'b0;
            rr      <= '0;
        end else if (free) begin
            if (found) begin
                ifb_o   <= head_ent[grant];
                ifb_v_o <= 1'b1;
                rr      <= tid_next(grant);
            end else begin
                ifb_v_o <= 1'b0;
            end
        end else if (flush_i[ifb_o.thread]) begin
            // Held entry of a flushed thread is dropped even while decode stalls.
            ifb_v_o <= 1'b0;
        end
    end

    // Simulation checks
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full[pt]));

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        ($past(rst_n) && $past(ifb_v_o) && !$past(dec_rdy_i) && ifb_v_o) |-> $stable(ifb_o));

    for (genvar t = 0; t < NTHREADS; t++) begin : g_chk
        a_cnt_max: assert property (@(posedge clk) disable iff (!rst_n)
            cnt[t] <= CW'(DEPTH));
    end

endmodule

// File: tb/tb_rfphoenix_ifetch_queue.sv
// Directed bench for rfphoenix_ifetch_queue with hand-computed expectations.
module tb_rfphoenix_ifetch_queue;
    import rfphoenix_ifetch_queue_pkg::*;

    localparam int CW = $clog2(IFQ_DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    InstructionFetchbuf       ifb_i;
    logic                     ifb_v_i;
    logic [NTHREADS-1:0]      full_o;
    logic [NTHREADS-1:0]      flush_i;
    logic [NTHREADS-1:0]      sleep_i;
    InstructionFetchbuf       ifb_o;
    logic                     ifb_v_o;
    logic                     dec_rdy_i;
    logic [NTHREADS*CW-1:0]   cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rfphoenix_ifetch_queue #(.DEPTH(IFQ_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ifb_i     (ifb_i),
        .ifb_v_i   (ifb_v_i),
        .full_o    (full_o),
        .flush_i   (flush_i),
        .sleep_i   (sleep_i),
        .ifb_o     (ifb_o),
        .ifb_v_o   (ifb_v_o),
        .dec_rdy_i (dec_rdy_i),
        .cnt_o     (cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int t, input logic [31:0] ip, input CauseCode c);
        ifb_i        = '0;
        ifb_i.v      = 1'b1;
        ifb_i.thread = Tid'(t);
        ifb_i.ip     = ip;
        ifb_i.insn   = ~ip;
        ifb_i.cause  = c;
        ifb_v_i      = 1'b1;
    endtask

    task automatic idle();
        ifb_i   = '0;
        ifb_v_i = 1'b0;
    endtask

    function automatic logic [63:0] cnt_of(input int t);
        return 64'(cnt_o[t*CW +: CW]);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        flush_i = '0;
        sleep_i = '0;
        dec_rdy_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int ord_t [6] = '{0, 2, 3, 0, 2, 3};
        int ord_k [6] = '{0, 0, 0, 1, 1, 1};

        do_reset();
        chk("rst_v", 64'(ifb_v_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_cnt", 64'(cnt_o), 64'd0);
        chk("rst_ifb", 64'(ifb_o.ip), 64'd0);

        // Basic ordering on thread 1, decode always ready
        dec_rdy_i = 1'b1;
        push(1, 32'h100, FLT_NONE);
        tick();
        chk("ord_lat_v", 64'(ifb_v_o), 64'd0);
        chk("ord_cnt1", cnt_of(1), 64'd1);
        push(1, 32'h105, FLT_IPF);
        tick();
        chk("ord_v0", 64'(ifb_v_o), 64'd1);
        chk("ord_ip0", 64'(ifb_o.ip), 64'h100);
        chk("ord_thr0", 64'(ifb_o.thread), 64'd1);
        push(1, 32'h10A, FLT_NONE);
        tick();
        chk("ord_ip1", 64'(ifb_o.ip), 64'h105);
        chk("ord_cause1", 64'(ifb_o.cause), 64'(FLT_IPF));
        idle();
        tick();
        chk("ord_ip2", 64'(ifb_o.ip), 64'h10A);
        chk("ord_cnt_end", cnt_of(1), 64'd0);
        tick();
        chk("ord_drain_v", 64'(ifb_v_o), 64'd0);

        // Round robin across threads 0, 2, 3
        do_reset();
        sleep_i = '1;
        foreach (ord_t[i]) begin
            push(ord_t[i], 32'h200 + 32'(ord_t[i] * 16 + ord_k[i]), FLT_NONE);
            tick();
        end
        idle();
        chk("rr_cnts", 64'(cnt_o), 64'h482);
        chk("rr_sleep_v", 64'(ifb_v_o), 64'd0);
        sleep_i = '0;
        dec_rdy_i = 1'b1;
        foreach (ord_t[i]) begin
            tick();
            chk($sformatf("rr_thr%0d", i), 64'(ifb_o.thread), 64'(ord_t[i]));
            chk($sformatf("rr_ip%0d", i), 64'(ifb_o.ip), 64'(32'h200 + 32'(ord_t[i] * 16 + ord_k[i])));
        end
        tick();
        chk("rr_end_v", 64'(ifb_v_o), 64'd0);

        // Fill thread 0 under backpressure, then drain
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push(0, 32'h300 + 32'(k), FLT_NONE);
            tick();
            if (k == 4) begin
                chk("full_set", 64'(full_o), 64'b0001);
                chk("full_cnt", cnt_of(0), 64'd4);
            end
        end
        idle();
        chk("full_drop_cnt", cnt_of(0), 64'd4);
        chk("full_hold_ip", 64'(ifb_o.ip), 64'h300);
        chk("full_hold_v", 64'(ifb_v_o), 64'd1);
        dec_rdy_i = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk($sformatf("drain_ip%0d", k), 64'(ifb_o.ip), 64'h300 + 64'(k));
            if (k == 1) chk("full_clr", 64'(full_o), 64'd0);
        end
        tick();
        chk("drain_end_v", 64'(ifb_v_o), 64'd0);

        // Flush of a held, staged thread
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(2, 32'h400 + 32'(k), FLT_NONE);
            tick();
        end
        chk("fl_pre_cnt", cnt_of(2), 64'd3);
        chk("fl_pre_ip", 64'(ifb_o.ip), 64'h400);
        flush_i = 4'b0100;
        push(2, 32'h4FF, FLT_NONE);
        tick();
        chk("fl_v", 64'(ifb_v_o), 64'd0);
        chk("fl_cnt", cnt_of(2), 64'd0);
        flush_i = '0;
        idle();
        tick();
        chk("fl_post_v", 64'(ifb_v_o), 64'd0);
        chk("fl_post_cnt", cnt_of(2), 64'd0);

        // Sleep gating
        do_reset();
        dec_rdy_i = 1'b1;
        sleep_i = 4'b0001;
        push(0, 32'h500, FLT_NONE);
        tick();
        push(1, 32'h510, FLT_NONE);
        tick();
        chk("sl_gate_v", 64'(ifb_v_o), 64'd0);
        idle();
        tick();
        chk("sl_thr1", 64'(ifb_o.thread), 64'd1);
        chk("sl_ip1", 64'(ifb_o.ip), 64'h510);
        tick();
        chk("sl_idle_v", 64'(ifb_v_o), 64'd0);
        chk("sl_cnt0", cnt_of(0), 64'd1);
        sleep_i = '0;
        tick();
        chk("sl_wake_v", 64'(ifb_v_o), 64'd1);
        chk("sl_wake_ip", 64'(ifb_o.ip), 64'h500);

        // Reset while full and staged
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push(3, 32'h600 + 32'(k), FLT_NONE);
            tick();
        end
        chk("mr_pre_full", 64'(full_o), 64'b1000);
        chk("mr_pre_v", 64'(ifb_v_o), 64'd1);
        rst_n = 1'b0;
        push(3, 32'h6FF, FLT_NONE);
        tick();
        chk("mr_cnt", 64'(cnt_o), 64'd0);
        chk("mr_v", 64'(ifb_v_o), 64'd0);
        chk("mr_full", 64'(full_o), 64'd0);
        rst_n = 1'b1;
        idle();
        tick();
        chk("mr_post_v", 64'(ifb_v_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
